fetch_ctrl: RTL and testbench

- Sequencing controller in front of the instruction-fetch stage.
- Arbitrates PC redirect requests (exception, EX-stage branch, ID-stage jump) and drives the fetch unit's ce/change_pc/pc inputs.
- Squashes wrong-path beats and buffers fetched instructions in a 2-entry skid buffer feeding decode with a valid/ready handshake.
- Asserts a flush pulse toward downstream stages on every redirect.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_skid_buf.sv | 56 +++++
 rtl/fetch_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencing controller.
//   redir_src_e   : redirect source encoding (NONE/JMP/BR/EXC)
//   DEF_*         : default reset PC and exception vector
//   fetch_entry_t : one skid-buffer entry {instr, pc} at default widths
//   redir_pick()  : fixed-priority redirect arbiter, exc > br > jmp
package fetch_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_EXC  = 2'd3
  } redir_src_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic redir_src_e redir_pick(input logic exc, input logic br, input logic jmp);
    if (exc) return SRC_EXC;
    if (br)  return SRC_BR;
    if (jmp) return SRC_JMP;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO between the fetch unit and decode.
//   f_clk, f_rst : clock, async active-low reset
//   push, din    : write one {instr,pc} entry
//   pop          : drop the head entry
//   flush        : empty the buffer (wins over push/pop)
//   count        : occupancy 0..2
//   head         : head entry, stable until popped
module fetch_skid_buf #(
  parameter int DW = 64
) (
  input  logic          f_clk,
  input  logic          f_rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);

  logic [1:0][DW-1:0] mem;
  logic               wr_ptr;
  logic               rd_ptr;

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The write slot only aliases the head when the buffer is empty, so the
  // head never changes under a stalled decode.
  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge f_clk) disable iff (!f_rst)
    !(push && !flush && count == 2'd2));

endmodule

// File: rtl/fetch_ctrl.sv
// Sequencing controller in front of instruction fetch.
//   f_clk, f_rst                 : clock, async active-low reset
//   c_i_run                      : global fetch enable
//   c_i_exc/br_taken/jmp (+tgt)  : redirect requests, priority exc > br > jmp
//   c_o_fetch_ce/change_pc/pc    : fetch unit control
//   c_i_fetch_vld/instr/pc       : fetch unit output beat
//   c_o_dec_vld/instr/pc, rdy    : decode valid/ready handshake
//   c_o_flush                    : one-cycle pulse after every redirect
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  IWIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEF_RESET_PC),
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic                f_clk,
  input  logic                f_rst,
  input  logic                c_i_run,
  input  logic                c_i_exc,
  input  logic                c_i_br_taken,
  input  logic [PC_WIDTH-1:0] c_i_br_target,
  input  logic                c_i_jmp,
  input  logic [PC_WIDTH-1:0] c_i_jmp_target,
  output logic                c_o_fetch_ce,
  output logic                c_o_change_pc,
  output logic [PC_WIDTH-1:0] c_o_pc,
  input  logic                c_i_fetch_vld,
  input  logic [IWIDTH-1:0]   c_i_fetch_instr,
  input  logic [PC_WIDTH-1:0] c_i_fetch_pc,
  output logic                c_o_dec_vld,
  output logic [IWIDTH-1:0]   c_o_dec_instr,
  output logic [PC_WIDTH-1:0] c_o_dec_pc,
  input  logic                c_i_dec_rdy,
  output logic                c_o_flush
);

  localparam int DW = IWIDTH + PC_WIDTH;

  redir_src_e          src;
  logic                req;
  logic [PC_WIDTH-1:0] win_target;
  logic [PC_WIDTH-1:0] target;
  logic                pending;
  logic                chg_q;
  logic                started;
  logic                consume;
  logic                push;
  logic                pop;
  logic [1:0]          count;
  logic [DW-1:0]       head;

  always_comb begin
    src        = redir_pick(c_i_exc, c_i_br_taken, c_i_jmp);
    req        = (src != SRC_NONE);
    win_target = target;
    case (src)
      SRC_EXC: win_target = EXC_VECTOR;
      SRC_BR:  win_target = c_i_br_target;
      SRC_JMP: win_target = c_i_jmp_target;
      default: win_target = target;
    endcase
  end

  // Fetch latches change_pc on the ack edge and shows the old-path beat one
  // cycle later; that beat is what retires the redirect.
  assign consume       = c_i_fetch_vld && chg_q;
  assign c_o_change_pc = started && pending && !consume;
  assign c_o_pc        = target;

  assign push         = c_i_fetch_vld && !pending && !req;
  assign pop          = c_o_dec_vld && c_i_dec_rdy;
  assign c_o_dec_vld  = (count != 2'd0);
  // Leave room for the beat already in flight from last cycle's ce.
  assign c_o_fetch_ce = c_i_run && (({1'b0, count} + {2'b0, push}) <= 3'd1);

  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      pending   <= (RESET_PC != '0);
      target    <= RESET_PC;
      chg_q     <= 1'b0;
      c_o_flush <= 1'b0;
      started   <= 1'b0;
    end else begin
      started   <= 1'b1;
      c_o_flush <= req;
      // An ack edge that coincides with a new request latched the old target
      // into fetch; its echo must not retire the new redirect.
      chg_q     <= c_o_change_pc && !req;
      if (req) begin
        pending <= 1'b1;
        target  <= win_target;
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

  fetch_skid_buf #(.DW(DW)) u_buf (
    .f_clk (f_clk),
    .f_rst (f_rst),
    .push  (push),
    .pop   (pop),
    .flush (req),
    .din   ({c_i_fetch_instr, c_i_fetch_pc}),
    .count (count),
    .head  (head)
  );

  assign {c_o_dec_instr, c_o_dec_pc} = head;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a behavioural fetch-unit model feeds
// the DUT; a path scoreboard predicts every PC decode must accept.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] EXC_V  = 32'h0000_0080;

  logic        f_clk = 1'b0;
  logic        f_rst = 1'b0;
  logic        c_i_run = 0, c_i_exc = 0, c_i_br_taken = 0, c_i_jmp = 0, c_i_dec_rdy = 0;
  logic [31:0] c_i_br_target = 0, c_i_jmp_target = 0;
  logic        c_o_fetch_ce, c_o_change_pc, c_o_dec_vld, c_o_flush;
  logic [31:0] c_o_pc, c_o_dec_instr, c_o_dec_pc;
  logic        c_i_fetch_vld;
  logic [31:0] c_i_fetch_instr, c_i_fetch_pc;

  always #5 f_clk = ~f_clk;

  fetch_ctrl #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(RST_PC), .EXC_VECTOR(EXC_V)) dut (
    .f_clk(f_clk), .f_rst(f_rst), .c_i_run(c_i_run), .c_i_exc(c_i_exc),
    .c_i_br_taken(c_i_br_taken), .c_i_br_target(c_i_br_target),
    .c_i_jmp(c_i_jmp), .c_i_jmp_target(c_i_jmp_target),
    .c_o_fetch_ce(c_o_fetch_ce), .c_o_change_pc(c_o_change_pc), .c_o_pc(c_o_pc),
    .c_i_fetch_vld(c_i_fetch_vld), .c_i_fetch_instr(c_i_fetch_instr), .c_i_fetch_pc(c_i_fetch_pc),
    .c_o_dec_vld(c_o_dec_vld), .c_o_dec_instr(c_o_dec_instr), .c_o_dec_pc(c_o_dec_pc),
    .c_i_dec_rdy(c_i_dec_rdy), .c_o_flush(c_o_flush)
  );

  function automatic logic [31:0] ifun(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Fetch unit: on a ce edge it emits the instruction at its PC and then moves
  // to the redirect target (if change_pc was high) or PC+4.
  logic [31:0] fpc;
  always @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      c_i_fetch_vld   <= 1'b0;
      c_i_fetch_pc    <= '0;
      c_i_fetch_instr <= '0;
      fpc             <= RST_PC;
    end else begin
      c_i_fetch_vld <= c_o_fetch_ce;
      if (c_o_fetch_ce) begin
        c_i_fetch_pc    <= fpc;
        c_i_fetch_instr <= ifun(fpc);
        fpc             <= c_o_change_pc ? c_o_pc : fpc + 32'd4;
      end
    end
  end

  int n_chk = 0, n_pass = 0, n_pops = 0, stall = 0, max_stall = 0;
  logic [31:0]  exp_pc = RST_PC;
  logic         prev_req = 0, prev_vld = 0, prev_rdy = 0;
  logic [31:0]  prev_tgt = 0;
  fetch_entry_t prev_ent = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    exp_pc = RST_PC; prev_req = 0; prev_vld = 0; prev_rdy = 0; stall = 0;
  endtask

  // Called at a negedge: drive, check this cycle, advance the model, wait.
  task automatic cyc(input logic run, input logic rdy, input logic exc, input logic br,
                     input logic [31:0] brt, input logic jmp, input logic [31:0] jt);
    logic req;
    c_i_run = run; c_i_dec_rdy = rdy; c_i_exc = exc;
    c_i_br_taken = br; c_i_br_target = brt; c_i_jmp = jmp; c_i_jmp_target = jt;
    #1;
    chk("flush", c_o_flush, prev_req);
    if (prev_req) begin
      chk("flush_vld", c_o_dec_vld, 0);
      chk("redir_pc", c_o_pc, prev_tgt);
    end
    if (prev_vld && !prev_rdy && !prev_req) begin
      chk("hold_vld", c_o_dec_vld, 1);
      chk("hold_ent", {c_o_dec_instr, c_o_dec_pc}, prev_ent);
    end
    if (!run) chk("ce_off", c_o_fetch_ce, 0);
    req = exc | br | jmp;
    if (c_o_dec_vld && rdy) begin
      chk("pop_pc", c_o_dec_pc, exp_pc);
      chk("pop_instr", c_o_dec_instr, ifun(exp_pc));
      exp_pc += 32'd4; n_pops++; stall = 0;
    end else if (run && rdy && !req) begin
      stall++;
      if (stall > max_stall) max_stall = stall;
    end else stall = 0;
    prev_req = req;
    prev_tgt = exc ? EXC_V : (br ? brt : jt);
    if (req) exp_pc = prev_tgt;
    prev_vld = c_o_dec_vld; prev_rdy = rdy;
    prev_ent = '{instr: c_o_dec_instr, pc: c_o_dec_pc};
    @(negedge f_clk);
  endtask

  task automatic idle(input logic run, input logic rdy);
    cyc(run, rdy, 0, 0, '0, 0, '0);
  endtask

  // Run with rdy=1 until change_pc drops (the consume cycle); bounded.
  task automatic wait_consume(input string tag);
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (!c_o_change_pc) seen = 1;
      else idle(1, 1);
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int p0;
    // Reset state
    #1;
    chk("rst_vld", c_o_dec_vld, 0);
    chk("rst_pc", c_o_dec_pc, 0);
    chk("rst_instr", c_o_dec_instr, 0);
    chk("rst_flush", c_o_flush, 0);
    chk("rst_chg", c_o_change_pc, 0);
    chk("rst_tgt", c_o_pc, RST_PC);
    @(negedge f_clk); @(negedge f_clk);
    f_rst = 1'b1;

    // Straight-line stream from RESET_PC, no redirect ever requested
    for (int i = 0; i < 8; i++) begin
      idle(1, 1);
      chk("no_chg", c_o_change_pc, 0);
    end
    chk("stream_pops", n_pops >= 3, 1);

    // Decode stalled: buffer fills, ce drops, then drains in order
    for (int i = 0; i < 6; i++) idle(1, 0);
    chk("full_ce", c_o_fetch_ce, 0);
    chk("full_vld", c_o_dec_vld, 1);
    for (int i = 0; i < 4; i++) idle(1, 1);
    for (int i = 0; i < 6; i++) idle(1, 0);

    // Branch to 0x40 with a full buffer
    cyc(1, 0, 0, 1, 32'h40, 0, '0);
    chk("br_chg", c_o_change_pc, 1);
    wait_consume("br_consume");
    p0 = n_pops;
    for (int i = 0; i < 6; i++) idle(1, 1);
    chk("br_chg_done", c_o_change_pc, 0);
    chk("br_delivered", n_pops > p0, 1);

    // All three sources at once: exception wins
    cyc(1, 1, 1, 1, 32'h40, 1, 32'h100);
    chk("exc_chg", c_o_change_pc, 1);
    for (int i = 0; i < 8; i++) idle(1, 1);
    // Branch beats jump
    cyc(1, 1, 0, 1, 32'h300, 1, 32'h500);
    for (int i = 0; i < 8; i++) idle(1, 1);

    // Jump to 0x100, branch to 0x200 on the consume cycle
    cyc(1, 1, 0, 0, '0, 1, 32'h100);
    wait_consume("jmp_consume");
    cyc(1, 1, 0, 1, 32'h200, 0, '0);
    chk("rebr_chg", c_o_change_pc, 1);
    for (int i = 0; i < 8; i++) idle(1, 1);

    // Unaligned target passes through verbatim
    cyc(1, 1, 0, 0, '0, 1, 32'h0000_0A03);
    for (int i = 0; i < 8; i++) idle(1, 1);

    // Async reset mid-stream with a full buffer
    for (int i = 0; i < 6; i++) idle(1, 0);
    #2 f_rst = 1'b0;
    #1;
    chk("arst_vld", c_o_dec_vld, 0);
    chk("arst_pc", c_o_dec_pc, 0);
    chk("arst_instr", c_o_dec_instr, 0);
    chk("arst_flush", c_o_flush, 0);
    chk("arst_chg", c_o_change_pc, 0);
    model_reset();
    @(negedge f_clk); @(negedge f_clk);
    f_rst = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 6; i++) idle(1, 1);
    chk("arst_restart", n_pops > p0, 1);

    // Randomized traffic
    p0 = n_pops;
    for (int i = 0; i < 1500; i++) begin
      logic run, rdy, exc, br, jmp;
      logic [31:0] brt, jt;
      run = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      exc = ($urandom_range(0, 39) == 0);
      br  = ($urandom_range(0, 19) == 0);
      jmp = ($urandom_range(0, 19) == 0);
      brt = {16'h0, 12'($urandom), 4'h0} | (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
      jt  = {16'h1, 12'($urandom), 4'h0} | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
      cyc(run, rdy, exc, br, brt, jmp, jt);
    end
    chk("rand_pops", n_pops > p0 + 200, 1);
    chk("max_stall", max_stall < 6, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
